uart_rx_8n1: RTL and testbench

Serial receiver for the lab 0 Zedboard UART path. It takes the asynchronous `rx_i` line (the jumper loop-back or the board pin), oversamples it 16x, and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. Each received byte is delivered through a one-entry valid/ready holding register to the LED driver or a bus wrapper. Framing and overrun events are flagged.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_8n1.sv | 156 +++++++++++++++
 tb/tb_uart_rx_8n1.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: FSM states, oversample
// ratio and the baud-tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int tick_div(input int clk_hz, input int baud);
        return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; clr_i restarts the count so the
// tick phase can be aligned to an external event such as a start edge.
module uart_baud_tick #(
    parameter int TICK_DIV = 54
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: 16x oversampling with 2-of-3 majority vote per bit,
// delivering bytes through a one-entry valid/ready holding register.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 115_200,
    parameter int TICK_DIV = tick_div(CLK_HZ, BAUD)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic      rx_meta_q, rx_s_q;
    rx_state_t state_q;
    logic [3:0] samp_q;
    logic [2:0] bit_q;
    logic [1:0] smp_q;
    logic [7:0] shift_q;
    logic       frame_err_q, overrun_q, overrun_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       tick, start_det, maj, good, xfer;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign start_det = (state_q == IDLE) && !rx_s_q;

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_det),
        .tick_o(tick)
    );

    // Samples 7 and 8 are held; the vote completes on the sample-9 tick.
    assign maj  = vote3(smp_q[1], smp_q[0], rx_s_q);
    assign good = (state_q == STOP) && tick && (samp_q == 4'd9) && maj;

    always_ff @(posedge clk_i) begin
        if (tick && (samp_q == 4'd7 || samp_q == 4'd8)) begin
            smp_q <= {smp_q[0], rx_s_q};
        end
        if ((state_q == DATA) && tick && (samp_q == 4'd9)) begin
            shift_q <= {maj, shift_q[7:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (tick && (state_q != IDLE)) begin
                samp_q <= samp_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    samp_q <= '0;
                    bit_q  <= '0;
                    if (!rx_s_q) state_q <= START;
                end
                START: begin
                    if (tick && (samp_q == 4'd9) && maj) begin
                        state_q <= IDLE;
                    end else if (tick && (samp_q == 4'd15)) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick && (samp_q == 4'd15)) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    // Re-arm mid stop bit so a slightly fast sender is tolerated.
                    if (tick && (samp_q == 4'd9)) begin
                        if (maj) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign xfer = valid_q && ready_i;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (good) begin
            if (!valid_q || xfer) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: frames are driven cycle by cycle, expected
// bytes go into a scoreboard queue and are checked on each valid/ready transfer.
module tb_uart_rx_8n1;

    localparam int BIT_CYC   = 868;  // 8680 ns at a 10 ns clock
    localparam int DUT_BIT   = 864;
    localparam int TICK      = 54;
    localparam int SPIKE_LEN = 57;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_vec = 0;
    int n_mis = 0;
    int vhi_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_rx_8n1 dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always @(negedge clk) begin
        if (valid_o === 1'b1) vhi_cnt++;
        if (frame_err_o === 1'b1) fe_cnt++;
        if (overrun_o === 1'b1) ov_cnt++;
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            xfer_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $error("FAIL unexpected_byte: got %02h expected none", data_o);
            end else begin
                exp_b = exp_q.pop_front();
                assert (data_o === exp_b) else begin
                    n_mis++;
                    $error("FAIL rx_byte: got %02h expected %02h", data_o, exp_b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        vhi_cnt  = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        xfer_cnt = 0;
    endtask

    // Drives one frame; spike_at inverts the line for SPIKE_LEN cycles,
    // rst_at pulses reset for one cycle and abandons the rest of the frame.
    task automatic drive_frame(input logic [7:0] d, input logic stop,
                               input int spike_at, input int rst_at);
        for (int c = 0; c < 10 * BIT_CYC; c++) begin
            int   b;
            logic lvl;
            b = c / BIT_CYC;
            if (b == 0) lvl = 1'b0;
            else if (b <= 8) lvl = d[b-1];
            else lvl = stop;
            if (spike_at >= 0 && c >= spike_at && c < spike_at + SPIKE_LEN) lvl = ~lvl;
            if (c == rst_at) begin
                rx_i  = 1'b1;
                rst_i = 1'b0;
                step();
                rst_i = 1'b1;
                return;
            end
            rx_i = lvl;
            step();
        end
        rx_i = 1'b1;
    endtask

    initial begin
        rx_i    = 1'b1;
        ready_i = 1'b0;
        rst_i   = 1'b0;
        repeat (3) step();
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 8'h00);
        check("rst_frame_err", frame_err_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_busy", busy_o, 0);
        rst_i = 1'b1;
        idle(20);

        // Single frame, consumer ready
        clear_counts();
        ready_i = 1'b1;
        exp_q.push_back(8'h41);
        drive_frame(8'h41, 1'b1, -1, -1);
        idle(100);
        check("single_xfer", xfer_cnt, 1);
        check("single_valid_cycles", vhi_cnt, 1);
        check("single_frame_err", fe_cnt, 0);
        check("single_overrun", ov_cnt, 0);

        // Back-to-back frames, consumer stalled
        clear_counts();
        ready_i = 1'b0;
        exp_q.push_back(8'h55);
        drive_frame(8'h55, 1'b1, -1, -1);
        drive_frame(8'hAA, 1'b1, -1, -1);
        idle(100);
        check("stall_valid", valid_o, 1);
        check("stall_data", data_o, 8'h55);
        check("stall_overrun", ov_cnt, 1);
        check("stall_frame_err", fe_cnt, 0);
        ready_i = 1'b1;
        step();
        step();
        check("stall_release_valid", valid_o, 0);
        check("stall_release_xfer", xfer_cnt, 1);

        // Bad stop bit, then a good frame
        clear_counts();
        drive_frame(8'h0F, 1'b0, -1, -1);
        idle(100);
        check("badstop_frame_err", fe_cnt, 1);
        check("badstop_valid", vhi_cnt, 0);
        check("badstop_busy", busy_o, 0);
        exp_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, -1, -1);
        idle(100);
        check("after_err_xfer", xfer_cnt, 1);
        check("after_err_frame_err", fe_cnt, 1);

        // Start glitch of 300 ns
        clear_counts();
        rx_i = 1'b0;
        repeat (30) step();
        check("glitch_busy_hi", busy_o, 1);
        rx_i = 1'b1;
        repeat (DUT_BIT) step();
        check("glitch_busy_lo", busy_o, 0);
        check("glitch_valid", vhi_cnt, 0);
        check("glitch_flags", fe_cnt + ov_cnt, 0);

        // One-tick spike on sample 8 of data bit 2
        clear_counts();
        exp_q.push_back(8'hC3);
        drive_frame(8'hC3, 1'b1, 3 * DUT_BIT + 9 * TICK + 3 - SPIKE_LEN / 2, -1);
        idle(100);
        check("noise_xfer", xfer_cnt, 1);
        check("noise_flags", fe_cnt + ov_cnt, 0);

        // Reset during data bit 4 with a byte waiting in the holding register
        clear_counts();
        ready_i = 1'b0;
        drive_frame(8'h99, 1'b1, -1, -1);
        idle(50);
        check("pre_reset_valid", valid_o, 1);
        drive_frame(8'h99, 1'b1, -1, 5 * BIT_CYC + 400);
        check("midrst_valid", valid_o, 0);
        check("midrst_data", data_o, 8'h00);
        check("midrst_busy", busy_o, 0);
        idle(DUT_BIT * 11);
        check("midrst_flags", fe_cnt + ov_cnt, 0);
        check("midrst_no_output", valid_o, 0);
        ready_i = 1'b1;
        exp_q.push_back(8'h99);
        drive_frame(8'h99, 1'b1, -1, -1);
        idle(100);
        check("after_rst_xfer", xfer_cnt, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
